// File: rtl/aes_mix_pkg.sv
// Shared GF(2^8) helpers, MixColumns coefficient rows and FSM encoding
// for the iterative AES column-mix engine.
package aes_mix_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mix_state_e;

   // Byte k holds the coefficient applied to b[(row+k)%4] of the column.
   localparam logic [31:0] FWD_COEF = 32'h01_01_03_02;
   localparam logic [31:0] INV_COEF = 32'h09_0d_0b_0e;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] c);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (c[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic [31:0] coef);
      logic [31:0] res;
      logic [7:0]  acc;
      res = '0;
      for (int unsigned r = 0; r < 4; r++) begin
         acc = '0;
         for (int unsigned k = 0; k < 4; k++) begin
            acc = acc ^ gmul(col[8*((r+k)%4) +: 8], coef[8*k +: 8]);
         end
         res[8*r +: 8] = acc;
      end
      return res;
   endfunction

endpackage

// File: rtl/aes_mixcol_lane.sv
// One-column MixColumns / InvMixColumns, purely combinational.
module aes_mixcol_lane
   import aes_mix_pkg::*;
#(
   parameter bit INV_EN = 1'b1
) (
   input  logic [31:0] i_col,
   input  logic        i_inv,
   output logic [31:0] o_col
);

   // With INV_EN=0 the inverse branch is constant-folded away.
   always_comb begin
      o_col = (INV_EN && i_inv) ? mix_col(i_col, INV_COEF) : mix_col(i_col, FWD_COEF);
   end

endmodule

// File: rtl/aes_mixcol_iter.sv
// Iterative MixColumns engine: LANES columns per cycle over a 128-bit state,
// valid/ready on both sides, one state in flight.
module aes_mixcol_iter
   import aes_mix_pkg::*;
#(
   parameter int unsigned LANES  = 4,
   parameter bit          INV_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic         inv_i,
   input  logic [127:0] data_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [127:0] data_o
);

   localparam int unsigned NCYC = 4 / LANES;
   localparam logic [1:0]  LAST = 2'(NCYC - 1);

   if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
      $error("aes_mixcol_iter: LANES must be 1, 2 or 4");
   end

   mix_state_e   r_fsm, w_fsm_nxt;
   logic [1:0]   r_cnt;
   logic         r_inv;
   logic [127:0] r_state;

   logic         w_accept;
   logic         w_mode;
   logic [1:0]   w_grp;
   logic [127:0] w_src;
   logic [127:0] w_mixed;
   logic [31:0]  w_lane_in  [LANES];
   logic [31:0]  w_lane_out [LANES];

   always_ff @(posedge clk) begin
      if (rst) r_fsm <= ST_IDLE;
      else     r_fsm <= w_fsm_nxt;
   end

   // Column group 0 is mixed on the accept edge itself, so the state reaches
   // DONE 4/LANES cycles after accept and DONE->DONE is possible at LANES=4.
   always_comb begin
      w_fsm_nxt = r_fsm;
      case (r_fsm)
         ST_IDLE: if (valid_i) w_fsm_nxt = (NCYC == 1) ? ST_DONE : ST_BUSY;
         ST_BUSY: if (r_cnt == LAST) w_fsm_nxt = ST_DONE;
         ST_DONE: begin
            if (ready_i) begin
               if (valid_i) w_fsm_nxt = (NCYC == 1) ? ST_DONE : ST_BUSY;
               else         w_fsm_nxt = ST_IDLE;
            end
         end
         default: w_fsm_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ready_o  = (r_fsm == ST_IDLE) | ((r_fsm == ST_DONE) & ready_i);
      valid_o  = (r_fsm == ST_DONE);
      data_o   = (r_fsm == ST_DONE) ? r_state : '0;
      w_accept = valid_i & ready_o;
   end

   always_comb begin
      w_src  = w_accept ? data_i : r_state;
      w_grp  = w_accept ? 2'd0 : r_cnt;
      w_mode = w_accept ? (inv_i & INV_EN) : r_inv;
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      always_comb w_lane_in[g] = w_src[32*(int'(w_grp)*LANES + g) +: 32];

      aes_mixcol_lane #(.INV_EN(INV_EN)) u_lane (
         .i_col (w_lane_in[g]),
         .i_inv (w_mode),
         .o_col (w_lane_out[g])
      );
   end

   always_comb begin
      w_mixed = w_src;
      for (int unsigned l = 0; l < LANES; l++) begin
         w_mixed[32*(int'(w_grp)*LANES + l) +: 32] = w_lane_out[l];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= '0;
         r_cnt   <= '0;
         r_inv   <= 1'b0;
      end else if (w_accept) begin
         r_state <= w_mixed;
         r_inv   <= inv_i & INV_EN;
         r_cnt   <= (NCYC == 1) ? 2'd0 : 2'd1;
      end else if (r_fsm == ST_BUSY) begin
         r_state <= w_mixed;
         r_cnt   <= (r_cnt == LAST) ? 2'd0 : r_cnt + 2'd1;
      end
   end

endmodule

// File: tb/tb_aes_mixcol_iter.sv
// Scoreboard bench for aes_mixcol_iter at LANES=4/2/1 and an INV_EN=0 build.
module tb_aes_mixcol_iter;

   logic               clk;
   logic               rst;
   logic [3:0]         vld_i, rdy_o, inv_i, vld_o, rdy_i;
   logic [3:0][127:0]  din, dout;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;

   int unsigned LAT   [4] = '{1, 2, 4, 1};
   bit          INVEN [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

   int unsigned FWD_M [4][4] = '{'{2,3,1,1}, '{1,2,3,1}, '{1,1,2,3}, '{3,1,1,2}};
   int unsigned INV_M [4][4] = '{'{14,11,13,9}, '{9,14,11,13}, '{13,9,14,11}, '{11,13,9,14}};

   localparam logic [127:0] T1_IN  = 128'h4c31262d_d5d4d4d4_5c220af2_455313db;
   localparam logic [127:0] T1_OUT = 128'hf8bd7e4d_d6d7d5d5_9d58dc9f_bca14d8e;

   typedef struct {
      int unsigned  dut;
      logic [127:0] data;
      int unsigned  acc;
      int unsigned  lat;
      bit           seen;
   } exp_t;
   exp_t sb[$];

   aes_mixcol_iter #(.LANES(4), .INV_EN(1'b1)) u_l4 (
      .clk(clk), .rst(rst), .valid_i(vld_i[0]), .ready_o(rdy_o[0]), .inv_i(inv_i[0]),
      .data_i(din[0]), .valid_o(vld_o[0]), .ready_i(rdy_i[0]), .data_o(dout[0]));
   aes_mixcol_iter #(.LANES(2), .INV_EN(1'b1)) u_l2 (
      .clk(clk), .rst(rst), .valid_i(vld_i[1]), .ready_o(rdy_o[1]), .inv_i(inv_i[1]),
      .data_i(din[1]), .valid_o(vld_o[1]), .ready_i(rdy_i[1]), .data_o(dout[1]));
   aes_mixcol_iter #(.LANES(1), .INV_EN(1'b1)) u_l1 (
      .clk(clk), .rst(rst), .valid_i(vld_i[2]), .ready_o(rdy_o[2]), .inv_i(inv_i[2]),
      .data_i(din[2]), .valid_o(vld_o[2]), .ready_i(rdy_i[2]), .data_o(dout[2]));
   aes_mixcol_iter #(.LANES(4), .INV_EN(1'b0)) u_fwd (
      .clk(clk), .rst(rst), .valid_i(vld_i[3]), .ready_o(rdy_o[3]), .inv_i(inv_i[3]),
      .data_i(din[3]), .valid_o(vld_o[3]), .ready_i(rdy_i[3]), .data_o(dout[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: textbook matrix product over GF(2^8), shift-and-add multiply.
   function automatic int unsigned gm(input int unsigned a, input int unsigned b);
      int unsigned p = 0;
      while (b != 0) begin
         if (b & 1) p = p ^ a;
         a = a << 1;
         if (a & 32'h100) a = a ^ 32'h11b;
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
      logic [127:0] res;
      int unsigned  acc;
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 0;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gm(int'(s[32*c+8*j +: 8]), inv ? INV_M[r][j] : FWD_M[r][j]);
            res[32*c+8*r +: 8] = acc[7:0];
         end
      end
      return res;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every transfer pops the scoreboard; first valid checks latency.
   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 4; d++) begin
            if (vld_o[d]) begin
               if (sb.size() == 0 || sb[0].dut != d) begin
                  chk($sformatf("spurious_valid_dut%0d", d), 128'(vld_o[d]), 128'd0);
               end else begin
                  if (!sb[0].seen) begin
                     chk($sformatf("latency_dut%0d", d), 128'(cyc - sb[0].acc), 128'(sb[0].lat));
                     sb[0].seen = 1'b1;
                  end
                  if (rdy_i[d]) begin
                     chk($sformatf("data_dut%0d", d), dout[d], sb[0].data);
                     void'(sb.pop_front());
                  end
               end
            end
         end
      end
   end

   // Driver: issues one state, pushes its expected result when accepted.
   task automatic send(input int unsigned d, input logic [127:0] data, input logic inv,
                       input logic [127:0] exp, output int unsigned acc);
      bit got = 1'b0;
      vld_i[d] = 1'b1;
      din[d]   = data;
      inv_i[d] = inv;
      acc      = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (rdy_o[d]) begin
            sb.push_back('{dut: d, data: exp, acc: cyc, lat: LAT[d], seen: 1'b0});
            acc = cyc;
            got = 1'b1;
         end
         @(posedge clk); #1;
      end
      vld_i[d] = 1'b0;
      if (!got) chk($sformatf("accept_timeout_dut%0d", d), 128'd0, 128'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", 128'(sb.size()), 128'd0);
         sb.delete();
      end
   endtask

   initial begin
      int unsigned  a;
      int unsigned  accs [3];
      logic [127:0] r, e;
      logic         iv;

      rst = 1'b1; vld_i = '0; inv_i = '0; rdy_i = '1; din = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
         chk($sformatf("reset_valid_dut%0d", d), 128'(vld_o[d]), 128'd0);
         chk($sformatf("reset_data_dut%0d", d), dout[d], 128'd0);
         chk($sformatf("reset_ready_dut%0d", d), 128'(rdy_o[d]), 128'd1);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      send(0, T1_IN, 1'b0, T1_OUT, a);
      drain();
      for (int d = 0; d < 3; d++) begin
         send(d, T1_OUT, 1'b1, T1_IN, a);
         drain();
      end

      for (int d = 0; d < 4; d++) begin
         send(d, {4{32'h01010101}}, 1'b0, {4{32'h01010101}}, a);
         send(d, {4{32'hc6c6c6c6}}, 1'b1, {4{32'hc6c6c6c6}}, a);
         drain();
      end

      // Backpressure held for five cycles in DONE.
      e = ref_mix(T1_OUT, 1'b0);
      rdy_i[0] = 1'b0;
      send(0, T1_OUT, 1'b0, e, a);
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", 128'(vld_o[0]), 128'd1);
         chk("bp_ready", 128'(rdy_o[0]), 128'd0);
         chk("bp_data", dout[0], e);
         @(posedge clk); #1;
      end
      rdy_i[0] = 1'b1;
      @(posedge clk); #1;
      chk("bp_single_transfer", 128'(vld_o[0]), 128'd0);
      drain();

      // Back-to-back on LANES=2.
      for (int i = 0; i < 3; i++) begin
         r = {$urandom, $urandom, $urandom, $urandom};
         send(1, r, 1'b0, ref_mix(r, 1'b0), accs[i]);
      end
      for (int i = 1; i < 3; i++)
         chk("b2b_spacing", 128'(accs[i] - accs[i-1]), 128'd2);
      drain();

      // Reset two cycles into BUSY on LANES=1.
      send(2, T1_IN, 1'b0, T1_OUT, a);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      chk("rst_mid_valid", 128'(vld_o[2]), 128'd0);
      chk("rst_mid_data", dout[2], 128'd0);
      chk("rst_mid_ready", 128'(rdy_o[2]), 128'd1);
      send(2, T1_IN, 1'b0, T1_OUT, a);
      drain();

      send(3, T1_OUT, 1'b1, ref_mix(T1_OUT, 1'b0), a);
      drain();

      for (int d = 0; d < 4; d++) begin
         for (int n = 0; n < 8; n++) begin
            r  = {$urandom, $urandom, $urandom, $urandom};
            iv = 1'($urandom_range(0, 1));
            send(d, r, iv, ref_mix(r, iv & INVEN[d]), a);
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
         end
         drain();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
